// File: rtl/mult_pkg.sv
// Shared constants, helpers and types for the tiled multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_TILE = 8;
  localparam int unsigned MULT_LATENCY = 4;

  // Widest product the tiled multiplier is used for (64x64 operands).
  localparam int unsigned MAX_PROD_W   = 128;

  // Carry-save pair; sum + carry (mod 2^width) is the represented value.
  // Sized for the widest product. The multiplier declares its own copy
  // sized to its parameters so it carries no unused bits.
  typedef struct packed {
    logic [MAX_PROD_W-1:0] sum;
    logic [MAX_PROD_W-1:0] carry;
  } csa_pair_t;

  // Tiles per operand edge.
  function automatic int unsigned num_tiles(input int unsigned width,
                                            input int unsigned tile);
    return width / tile;
  endfunction

endpackage

// File: rtl/mult_tile.sv
// Combinational TILE x TILE unsigned multiplier producing a 2*TILE product.
//  a, b : tile operands
//  p    : full-width unsigned product
module mult_tile
  import mult_pkg::*;
#(
  parameter int unsigned TILE = DEFAULT_TILE
) (
  input  logic [TILE-1:0]   a,
  input  logic [TILE-1:0]   b,
  output logic [2*TILE-1:0] p
);

  assign p = (2*TILE)'(a) * (2*TILE)'(b);

endmodule

// File: rtl/pipelined_tile_multiplier.sv
// Four-stage WIDTH x WIDTH multiplier built from TILE x TILE tile products,
// unsigned or two's complement per transaction, valid/ready on both sides.
//  clk, rst            : clock, asynchronous active-high reset
//  in_valid/in_ready   : operand handshake (in_ready is combinational)
//  in_a, in_b          : operands
//  in_signed           : 1 = both operands two's complement
//  out_valid/out_ready : product handshake
//  out_product         : 2*WIDTH-bit product
//  busy                : any stage holds a valid transaction
module pipelined_tile_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TILE  = DEFAULT_TILE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int unsigned NT    = num_tiles(WIDTH, TILE);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned TPW   = 2 * TILE;
  localparam int unsigned NPROD = NT * NT;
  // Tile products, two correction rows, and the +2 that completes both negations.
  localparam int unsigned NROWS = NPROD + 3;

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } csa_t;

  if ((WIDTH % TILE) != 0) begin : g_bad_width
    $error("pipelined_tile_multiplier: WIDTH must be a multiple of TILE");
  end

  // Global stall: every stage advances together or not at all.
  logic en;
  logic accept;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Stage 1: operand capture.
  logic             v1;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_signed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
    end else if (en) begin
      v1        <= accept;
      s1_a      <= in_a;
      s1_b      <= in_b;
      s1_signed <= in_signed;
    end
  end

  // Tile products; entry (i*NT+j) is a slice i times b slice j.
  logic [NPROD*TPW-1:0] tp;

  for (genvar i = 0; i < NT; i++) begin : g_ti
    for (genvar j = 0; j < NT; j++) begin : g_tj
      mult_tile #(.TILE(TILE)) u_tile (
        .a (s1_a[i*TILE +: TILE]),
        .b (s1_b[j*TILE +: TILE]),
        .p (tp[(i*NT+j)*TPW +: TPW])
      );
    end
  end

  // Stage 2: tile products and signed corrections.
  logic                 v2;
  logic [NPROD*TPW-1:0] s2_tp;
  logic [WIDTH-1:0]     s2_corr_a;
  logic [WIDTH-1:0]     s2_corr_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2        <= 1'b0;
      s2_tp     <= '0;
      s2_corr_a <= '0;
      s2_corr_b <= '0;
    end else if (en) begin
      v2        <= v1;
      s2_tp     <= tp;
      s2_corr_a <= (s1_signed && s1_a[WIDTH-1]) ? s1_b : '0;
      s2_corr_b <= (s1_signed && s1_b[WIDTH-1]) ? s1_a : '0;
    end
  end

  // Each tile product lands on its diagonal weight 2^((i+j)*TILE).
  logic [PW-1:0] rows [NROWS];

  for (genvar i = 0; i < NT; i++) begin : g_ri
    for (genvar j = 0; j < NT; j++) begin : g_rj
      assign rows[i*NT+j] = PW'(s2_tp[(i*NT+j)*TPW +: TPW]) << ((i + j) * TILE);
    end
  end

  // -(corr << WIDTH) = ~(corr << WIDTH) + 1; the two +1s are merged into one row of 2.
  assign rows[NPROD]   = {~s2_corr_a, {WIDTH{1'b1}}};
  assign rows[NPROD+1] = {~s2_corr_b, {WIDTH{1'b1}}};
  assign rows[NPROD+2] = PW'(2);

  // 3:2 compression of all rows into one carry-save pair.
  csa_t csa_d;

  always_comb begin : csa_chain
    logic [PW-1:0] s_t;
    logic [PW-1:0] c_t;
    logic [PW-1:0] s_n;
    logic [PW-1:0] c_n;
    s_t = '0;
    c_t = '0;
    s_n = '0;
    c_n = '0;
    for (int r = 0; r < NROWS; r++) begin
      s_n = s_t ^ c_t ^ rows[r];
      c_n = ((s_t & c_t) | (s_t & rows[r]) | (c_t & rows[r])) << 1;
      s_t = s_n;
      c_t = c_n;
    end
    csa_d.sum   = s_t;
    csa_d.carry = c_t;
  end

  // Stage 3: carry-save result.
  logic v3;
  csa_t s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
      s3 <= '0;
    end else if (en) begin
      v3 <= v2;
      s3 <= csa_d;
    end
  end

  // Stage 4: carry-propagate add; product register only moves for valid data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (en) begin
      out_valid <= v3;
      if (v3) begin
        out_product <= s3.sum + s3.carry;
      end
    end
  end

  // busy tracks the OR of the next-cycle stage valids; it holds during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (en) begin
      busy <= accept | v1 | v2 | v3;
    end
  end

endmodule

// File: tb/tb_pipelined_tile_multiplier.sv
// Directed and randomized checks of pipelined_tile_multiplier at 32/8, 16/4 and 64/16.
module tb_pipelined_tile_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        iv, ir, sg, ov, ordy, busy;
  logic [31:0] a, b;
  logic [63:0] prod;

  logic        iv16, ir16, sg16, ov16, ordy16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  logic         iv64, ir64, sg64, ov64, ordy64, busy64;
  logic [63:0]  a64, b64;
  logic [127:0] prod64;

  pipelined_tile_multiplier #(.WIDTH(32), .TILE(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b),
    .in_signed(sg), .out_valid(ov), .out_ready(ordy), .out_product(prod), .busy(busy));

  pipelined_tile_multiplier #(.WIDTH(16), .TILE(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_signed(sg16), .out_valid(ov16), .out_ready(ordy16), .out_product(prod16), .busy(busy16));

  pipelined_tile_multiplier #(.WIDTH(64), .TILE(16)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_a(a64), .in_b(b64),
    .in_signed(sg64), .out_valid(ov64), .out_ready(ordy64), .out_product(prod64), .busy(busy64));

  // Reference: sign/zero-extend to 128 bits, multiply, keep 2*w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input logic s, input int w);
    logic [127:0] opm, pm, ex, ey;
    opm = (128'(1) << w) - 128'(1);
    pm  = (w == 64) ? '1 : ((128'(1) << (2 * w)) - 128'(1));
    ex  = 128'(x) & opm;
    ey  = 128'(y) & opm;
    if (s && x[w-1]) ex = ex | ~opm;
    if (s && y[w-1]) ey = ey | ~opm;
    return (ex * ey) & pm;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated transaction on the 32-bit DUT; called at a negedge.
  task automatic single32(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vs, input logic [63:0] expv);
    int lat;
    a = va; b = vb; sg = vs; iv = 1'b1; ordy = 1'b1;
    #1 check({tag, "_in_ready"}, 128'(ir), 128'(1));
    @(negedge clk);
    iv = 1'b0;
    lat = 1;
    while (!ov && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(4));
    check({tag, "_product"}, 128'(prod), 128'(expv));
    @(negedge clk);
    check({tag, "_one_pulse"}, 128'(ov), 128'(0));
  endtask

  // Stream n random transactions (alternating signedness) with an optional stall window.
  task automatic stream32(input string tag, input int n, input int stall_at, input int stall_len);
    logic [63:0] exp_q [$];
    logic [63:0] held, last_prod;
    bit pending, held_ok;
    int sent, got, first, last;
    pending = 0; held_ok = 0; sent = 0; got = 0; first = -1; last = -1;
    held = '0; last_prod = '0;
    for (int c = 0; c < n + 40 && got < n; c++) begin
      ordy = !(c >= stall_at && c < stall_at + stall_len);
      if (!pending && sent < n) begin
        a = $urandom; b = $urandom; sg = sent[0]; pending = 1;
      end
      iv = pending;
      #1;
      if (ov && ordy) begin
        if (exp_q.size() == 0) check({tag, "_spurious"}, 128'(ov), 128'(0));
        else check({tag, "_data"}, 128'(prod), 128'(exp_q.pop_front()));
        got++;
        if (first < 0) first = c;
        last = c;
        last_prod = prod;
      end
      if (ov && !ordy) begin
        check({tag, "_stall_in_ready"}, 128'(ir), 128'(0));
        if (held_ok) check({tag, "_stall_hold"}, 128'(prod), 128'(held));
        held = prod;
        held_ok = 1;
      end else begin
        held_ok = 0;
      end
      if (iv && ir) begin
        exp_q.push_back(64'(ref_mul(64'(a), 64'(b), sg, 32)));
        pending = 0;
        sent++;
      end
      @(negedge clk);
    end
    iv = 1'b0; ordy = 1'b1;
    check({tag, "_count"}, 128'(got), 128'(n));
    if (stall_len == 0) check({tag, "_back_to_back"}, 128'(last - first), 128'(n - 1));
    for (int k = 0; k < 3; k++) begin
      check({tag, "_no_extra"}, 128'(ov), 128'(0));
      @(negedge clk);
    end
    check({tag, "_bubble_hold"}, 128'(prod), 128'(last_prod));
  endtask

  initial begin
    int n_sw, sent16, got16, sent64, got64;
    bit pend16, pend64;
    logic [31:0]  q16 [$];
    logic [127:0] q64 [$];

    rst = 1'b1;
    iv = 0; a = '0; b = '0; sg = 0; ordy = 1;
    iv16 = 0; a16 = '0; b16 = '0; sg16 = 0; ordy16 = 1;
    iv64 = 0; a64 = '0; b64 = '0; sg64 = 0; ordy64 = 1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(ov), 128'(0));
    check("rst_product", 128'(prod), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(ir), 128'(1));
    check("rst_out_valid16", 128'(ov16), 128'(0));
    check("rst_out_valid64", 128'(ov64), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    single32("unsigned_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    single32("signed_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    single32("signed_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    single32("signed_5xm1", 32'd5, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
    single32("unsigned_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);

    stream32("stream", 20, 0, 0);
    stream32("backpressure", 6, 4, 3);

    // Reset with three transactions in flight.
    a = 32'd3; b = 32'd4; sg = 0; iv = 1;
    @(negedge clk);
    a = 32'hFFFF_FFF0; b = 32'd2; sg = 1;
    @(negedge clk);
    a = 32'd100; b = 32'd100; sg = 0;
    @(negedge clk);
    iv = 0;
    check("inflight_busy", 128'(busy), 128'(1));
    check("inflight_no_result", 128'(ov), 128'(0));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(ov), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_in_ready", 128'(ir), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_idle", 128'(ov), 128'(0));
    end
    single32("postrst", 32'd7, 32'd6, 1'b0, 64'd42);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("postrst_no_stale", 128'(ov), 128'(0));
    end

    // Random sweep on the 16/4 and 64/16 instances with random backpressure.
    n_sw = 10000;
    sent16 = 0; got16 = 0; sent64 = 0; got64 = 0; pend16 = 0; pend64 = 0;
    for (int c = 0; c < 3 * n_sw && (got16 < n_sw || got64 < n_sw); c++) begin
      ordy16 = ($urandom_range(0, 3) != 0);
      ordy64 = ($urandom_range(0, 3) != 0);
      if (!pend16 && sent16 < n_sw) begin
        a16 = (sent16 < 2) ? 16'hFFFF : (sent16 < 4) ? 16'h8000 : 16'($urandom);
        b16 = (sent16 < 4) ? a16 : 16'($urandom);
        sg16 = sent16[0] ^ 1'($urandom_range(0, 1));
        pend16 = 1;
      end
      if (!pend64 && sent64 < n_sw) begin
        a64 = (sent64 < 2) ? 64'hFFFF_FFFF_FFFF_FFFF : (sent64 < 4) ? 64'h8000_0000_0000_0000 :
              {$urandom, $urandom};
        b64 = (sent64 < 4) ? a64 : {$urandom, $urandom};
        sg64 = sent64[0] ^ 1'($urandom_range(0, 1));
        pend64 = 1;
      end
      iv16 = pend16;
      iv64 = pend64;
      #1;
      if (ov16 && ordy16) begin
        if (q16.size() == 0) check("sweep16_spurious", 128'(ov16), 128'(0));
        else check("sweep16", 128'(prod16), 128'(q16.pop_front()));
        got16++;
      end
      if (ov64 && ordy64) begin
        if (q64.size() == 0) check("sweep64_spurious", 128'(ov64), 128'(0));
        else check("sweep64", prod64, q64.pop_front());
        got64++;
      end
      if (iv16 && ir16) begin
        q16.push_back(32'(ref_mul(64'(a16), 64'(b16), sg16, 16)));
        pend16 = 0;
        sent16++;
      end
      if (iv64 && ir64) begin
        q64.push_back(ref_mul(a64, b64, sg64, 64));
        pend64 = 0;
        sent64++;
      end
      @(negedge clk);
    end
    iv16 = 0; iv64 = 0; ordy16 = 1; ordy64 = 1;
    check("sweep16_count", 128'(got16), 128'(n_sw));
    check("sweep64_count", 128'(got64), 128'(n_sw));
    repeat (3) @(negedge clk);
    check("sweep16_drained", 128'(busy16), 128'(0));
    check("sweep64_drained", 128'(busy64), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
